dma_burst_engine: RTL and testbench

Parametrised successor of the single-width DMA transfer engine. It moves `length` bytes between a byte address and a valid/ready data stream over an AXI4 master subset. Data width, burst cap and boundary size are configurable, and both data streams support backpressure. Each transfer is split into INCR bursts that never exceed `MAX_BURST` beats and never cross a `BOUNDARY`-byte line. Byte alignment is expressed through strobes only: stream data is lane-aligned exactly as in memory, and the block does no byte shifting. It sits between the peripheral datapath (e.g. Ethernet buffers) and the system AXI interconnect.

---
 rtl/dma_burst_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_dma_burst_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_engine.sv
// Burst DMA engine: moves a byte range between memory and a valid/ready stream
// over an AXI4 master subset, splitting into capped, boundary-safe INCR bursts.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// CALC  | size the next burst from remaining beats, burst cap and boundary
// ADDR  | AW/AR valid held with cur/AxLEN until accepted
// DATA  | stream <-> W/R beats pass through combinationally
// RESP  | write only: bready held until B arrives
// DONE  | zero-length transfer completion pulse
module dma_burst_engine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 256,
    parameter int BOUNDARY  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [LEN_W-1:0]    length,
    input  logic                read_not_write,
    output logic                ready,
    output logic                done,
    output logic                error,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_strb,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int BND_W = $clog2(BOUNDARY);
    localparam int TW    = LEN_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_ADDR, S_DATA, S_RESP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [LEN_W:0]      rem_q, rem_d;
    logic [8:0]          beats_q, beats_d;
    logic [7:0]          axlen_q, axlen_d;
    logic [8:0]          cnt_q, cnt_d;
    logic                first_q, first_d;
    logic [LB-1:0]       off_q, off_d;
    logic [LB:0]         lanes_q, lanes_d;
    logic                rnw_q, rnw_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic [TW-1:0]       span, span_m1, tot;
    logic [BND_W:0]      bnd_rem;
    logic [31:0]         beats_calc;
    logic                last_beat, final_burst, xfer_last;
    logic [BYTES-1:0]    mask_first, mask_last, strb;
    logic [LEN_W:0]      rem_after;
    logic [ADDR_W-1:0]   cur_step;
    logic                wr_phase, rd_phase;

    always_comb begin
        span    = TW'(length) + TW'(addr[LB-1:0]);
        span_m1 = span - TW'(1);
        tot     = (span + TW'(BYTES - 1)) >> LB;
        bnd_rem = (BND_W+1)'(BOUNDARY) - (BND_W+1)'(cur_q[BND_W-1:0]);

        // beats = min(remaining, burst cap, beats left before the boundary line)
        beats_calc = 32'(rem_q);
        if (beats_calc > 32'(MAX_BURST))
            beats_calc = 32'(MAX_BURST);
        if (beats_calc > 32'(bnd_rem >> LB))
            beats_calc = 32'(bnd_rem >> LB);
    end

    assign last_beat   = (cnt_q == beats_q - 9'd1);
    assign final_burst = (rem_q == (LEN_W+1)'(beats_q));
    assign xfer_last   = last_beat && final_burst;
    assign mask_first  = {BYTES{1'b1}} << off_q;
    assign mask_last   = ~({BYTES{1'b1}} << lanes_q);
    assign strb        = (first_q ? mask_first : {BYTES{1'b1}}) &
                         (xfer_last ? mask_last : {BYTES{1'b1}});
    assign rem_after   = rem_q - (LEN_W+1)'(beats_q);
    assign cur_step    = ADDR_W'(beats_q) << LB;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        axlen_d = axlen_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        off_d   = off_q;
        lanes_d = lanes_q;
        rnw_d   = rnw_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (length == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d   = addr & ~ADDR_W'(BYTES - 1);
                        rem_d   = (LEN_W+1)'(tot);
                        off_d   = addr[LB-1:0];
                        lanes_d = (LB+1)'(span_m1 & TW'(BYTES - 1)) + (LB+1)'(1);
                        rnw_d   = read_not_write;
                        first_d = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                beats_d = 9'(beats_calc);
                axlen_d = 8'(beats_calc - 32'd1);
                state_d = S_ADDR;
            end
            S_ADDR: begin
                cnt_d = '0;
                if (rnw_q ? m_axi_arready : m_axi_awready)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (!rnw_q) begin
                    if (in_valid && m_axi_wready) begin
                        cnt_d   = cnt_q + 9'd1;
                        first_d = 1'b0;
                        if (last_beat)
                            state_d = S_RESP;
                    end
                end else if (m_axi_rvalid && out_ready) begin
                    cnt_d   = cnt_q + 9'd1;
                    first_d = 1'b0;
                    if (m_axi_rresp != 2'b00)
                        err_d = 1'b1;
                    if (m_axi_rlast) begin
                        cur_d   = cur_q + cur_step;
                        rem_d   = rem_after;
                        done_d  = (rem_after == '0);
                        state_d = (rem_after == '0) ? S_IDLE : S_CALC;
                    end
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00)
                        err_d = 1'b1;
                    cur_d   = cur_q + cur_step;
                    rem_d   = rem_after;
                    done_d  = (rem_after == '0);
                    state_d = (rem_after == '0) ? S_IDLE : S_CALC;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            axlen_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            off_q   <= '0;
            lanes_q <= '0;
            rnw_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            axlen_q <= axlen_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            off_q   <= off_d;
            lanes_q <= lanes_d;
            rnw_q   <= rnw_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Data outputs are gated to the active phase so idle/reset values are zero.
    assign wr_phase = (state_q == S_DATA) && !rnw_q;
    assign rd_phase = (state_q == S_DATA) && rnw_q;

    assign ready         = (state_q == S_IDLE);
    assign done          = done_q;
    assign error         = err_q;

    assign m_axi_awaddr  = cur_q;
    assign m_axi_araddr  = cur_q;
    assign m_axi_awlen   = axlen_q;
    assign m_axi_arlen   = axlen_q;
    assign m_axi_awvalid = (state_q == S_ADDR) && !rnw_q;
    assign m_axi_arvalid = (state_q == S_ADDR) && rnw_q;

    assign m_axi_wdata   = wr_phase ? in_data : '0;
    assign m_axi_wstrb   = wr_phase ? strb : '0;
    assign m_axi_wlast   = wr_phase && last_beat;
    assign m_axi_wvalid  = wr_phase && in_valid;
    assign in_ready      = wr_phase && m_axi_wready;
    assign m_axi_bready  = (state_q == S_RESP);

    assign out_data      = rd_phase ? m_axi_rdata : '0;
    assign out_strb      = rd_phase ? strb : '0;
    assign out_last      = rd_phase && xfer_last;
    assign out_valid     = rd_phase && m_axi_rvalid;
    assign m_axi_rready  = rd_phase && out_ready;

endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine (32-bit data, 16-beat cap, 4 KB lines)
// with a small AXI slave / stream model that logs every handshake.
module tb_dma_burst_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int BY = DW / 8;

    logic          clk, rst, start, read_not_write;
    logic [AW-1:0] addr;
    logic [LW-1:0] length;
    logic          ready, done, error;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic [BY-1:0] out_strb;
    logic          out_last, out_valid, out_ready;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic          awvalid, awready, wlast, wvalid, wready;
    logic [DW-1:0] wdata, rdata;
    logic [BY-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rlast, rvalid, rready;

    dma_burst_engine #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(16), .BOUNDARY(4096)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .length(length),
        .read_not_write(read_not_write), .ready(ready), .done(done), .error(error),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_strb(out_strb), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Controls written by the main sequence, read by the slave model.
    logic       src_en = 1'b0, src_tgl = 1'b0, snk_en = 1'b0, snk_tgl = 1'b0;
    logic [1:0] bresp_plan [8];
    int         clr_gen = 0;

    // Logs written only by the slave model.
    logic [AW-1:0] aw_addr_q[$], ar_addr_q[$];
    int            aw_len_q[$], ar_len_q[$], aw_cyc_q[$], ar_cyc_q[$];
    int            b_cyc_q[$], rl_cyc_q[$];
    logic [BY-1:0] w_strb_q[$], o_strb_q[$];
    logic          w_last_q[$], o_last_q[$];
    logic [DW-1:0] w_data_q[$], o_data_q[$];
    int            valid_seen, cyc;

    // Drive slave/stream inputs 1 unit after the edge, sample 2 units before the next.
    initial begin
        int clr_seen, src_cnt, r_cnt, r_left, b_idx;
        logic b_pend;
        clr_seen = 0; src_cnt = 0; r_cnt = 0; r_left = 0; b_idx = 0;
        b_pend = 1'b0; valid_seen = 0; cyc = 0;
        in_valid = 1'b0; in_data = 32'hA000_0000; out_ready = 1'b0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00;
        rvalid = 1'b0; rdata = 32'hD000_0000; rresp = 2'b00; rlast = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (clr_gen != clr_seen) begin
                clr_seen = clr_gen;
                aw_addr_q.delete(); ar_addr_q.delete(); aw_len_q.delete(); ar_len_q.delete();
                aw_cyc_q.delete(); ar_cyc_q.delete(); b_cyc_q.delete(); rl_cyc_q.delete();
                w_strb_q.delete(); o_strb_q.delete(); w_last_q.delete(); o_last_q.delete();
                w_data_q.delete(); o_data_q.delete();
                src_cnt = 0; r_cnt = 0; b_idx = 0; valid_seen = 0;
            end
            in_valid  = src_en && (!src_tgl || !in_valid);
            in_data   = 32'hA000_0000 + 32'(src_cnt);
            out_ready = snk_en && (!snk_tgl || !out_ready);
            rvalid    = (r_left > 0);
            rlast     = (r_left == 1);
            rdata     = 32'hD000_0000 + 32'(r_cnt);
            bvalid    = b_pend;
            bresp     = b_pend ? bresp_plan[b_idx % 8] : 2'b00;
            #7;
            if (!rst) begin
                r_left = 0;
                b_pend = 1'b0;
            end else begin
                if (awvalid || arvalid || wvalid || out_valid) valid_seen++;
                if (rvalid && rready) begin
                    o_strb_q.push_back(out_strb);
                    o_last_q.push_back(out_last);
                    o_data_q.push_back(out_data);
                    if (rlast) rl_cyc_q.push_back(cyc);
                    r_cnt++;
                    r_left--;
                end
                if (bvalid && bready) begin
                    b_cyc_q.push_back(cyc);
                    b_pend = 1'b0;
                    b_idx++;
                end
                if (awvalid && awready) begin
                    aw_addr_q.push_back(awaddr);
                    aw_len_q.push_back(int'(awlen));
                    aw_cyc_q.push_back(cyc);
                end
                if (arvalid && arready) begin
                    ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(int'(arlen));
                    ar_cyc_q.push_back(cyc);
                    r_left = int'(arlen) + 1;
                end
                if (wvalid && wready) begin
                    w_strb_q.push_back(wstrb);
                    w_last_q.push_back(wlast);
                    w_data_q.push_back(wdata);
                    src_cnt++;
                    if (wlast) b_pend = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 8; i++) bresp_plan[i] = 2'b00;
        clr_gen++;
        tick();
    endtask

    task automatic go(input logic [AW-1:0] a, input logic [LW-1:0] len, input logic rnw);
        start = 1'b1; addr = a; length = len; read_not_write = rnw;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_ready_at_done"}, 64'(ready), 64'd1);
    endtask

    function automatic logic [63:0] pack_strb(input logic [BY-1:0] q[$]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < q.size() && i < 16; i++) r[4*i +: 4] = q[i];
        return r;
    endfunction

    function automatic logic [63:0] pack_bits(input logic q[$]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < q.size() && i < 64; i++) r[i] = q[i];
        return r;
    endfunction

    function automatic int count_ones(input logic q[$]);
        int n;
        n = 0;
        foreach (q[i]) if (q[i]) n++;
        return n;
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; addr = '0; length = '0; read_not_write = 1'b0;
        for (int i = 0; i < 8; i++) bresp_plan[i] = 2'b00;
        repeat (3) tick();

        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done_err", 64'({done, error}), 64'd0);
        chk("rst_handshakes", 64'({awvalid, arvalid, wvalid, bready, rready, in_ready, out_valid, out_last, wlast}), 64'd0);
        chk("rst_addrs", {awaddr, araddr}, 64'd0);
        chk("rst_len_strb", 64'({awlen, arlen, wstrb, out_strb}), 64'd0);
        chk("rst_data", {wdata, out_data}, 64'd0);
        rst = 1'b1;
        tick();

        // Aligned write, in_valid toggling.
        clear_logs();
        src_en = 1'b1; src_tgl = 1'b1;
        go(32'h1000, 16, 1'b0);
        chk("aw_start_ready_low", 64'(ready), 64'd0);
        chk("aw_start_no_valid_yet", 64'(awvalid), 64'd0);
        tick();
        chk("aw_valid_n2", 64'(awvalid), 64'd1);
        chk("aw_addr_n2", 64'(awaddr), 64'h1000);
        chk("aw_len_n2", 64'(awlen), 64'd3);
        wait_done("al_wr", 200);
        tick();
        chk("al_wr_done_pulse", 64'(done), 64'd0);
        src_en = 1'b0; src_tgl = 1'b0;
        chk("al_wr_aw_count", 64'(aw_addr_q.size()), 64'd1);
        chk("al_wr_awlen", 64'(aw_len_q[0]), 64'd3);
        chk("al_wr_beats", 64'(w_strb_q.size()), 64'd4);
        chk("al_wr_strb", pack_strb(w_strb_q), 64'hFFFF);
        chk("al_wr_wlast", pack_bits(w_last_q), 64'b1000);
        chk("al_wr_data0", 64'(w_data_q[0]), 64'hA000_0000);
        chk("al_wr_data3", 64'(w_data_q[3]), 64'hA000_0003);
        chk("al_wr_error", 64'(error), 64'd0);

        // Unaligned single-burst read.
        clear_logs();
        snk_en = 1'b1;
        go(32'h1003, 6, 1'b1);
        wait_done("ua_rd", 100);
        chk("ua_rd_ar_count", 64'(ar_addr_q.size()), 64'd1);
        chk("ua_rd_araddr", 64'(ar_addr_q[0]), 64'h1000);
        chk("ua_rd_arlen", 64'(ar_len_q[0]), 64'd2);
        chk("ua_rd_beats", 64'(o_strb_q.size()), 64'd3);
        chk("ua_rd_strb", pack_strb(o_strb_q), 64'h1F8);
        chk("ua_rd_last", pack_bits(o_last_q), 64'b100);
        chk("ua_rd_data0", 64'(o_data_q[0]), 64'hD000_0000);
        chk("ua_rd_data2", 64'(o_data_q[2]), 64'hD000_0002);
        chk("ua_rd_no_aw", 64'(aw_addr_q.size()), 64'd0);
        snk_en = 1'b0;

        // Boundary split write with SLVERR on the first burst.
        clear_logs();
        bresp_plan[0] = 2'b10;
        src_en = 1'b1;
        go(32'h0FF8, 32, 1'b0);
        wait_done("bnd_wr", 200);
        src_en = 1'b0;
        chk("bnd_wr_aw_count", 64'(aw_addr_q.size()), 64'd2);
        chk("bnd_wr_addr0", 64'(aw_addr_q[0]), 64'h0FF8);
        chk("bnd_wr_len0", 64'(aw_len_q[0]), 64'd1);
        chk("bnd_wr_addr1", 64'(aw_addr_q[1]), 64'h1000);
        chk("bnd_wr_len1", 64'(aw_len_q[1]), 64'd5);
        chk("bnd_wr_strb", pack_strb(w_strb_q), 64'hFFFF_FFFF);
        chk("bnd_wr_wlast", pack_bits(w_last_q), 64'h82);
        chk("bnd_wr_b_count", 64'(b_cyc_q.size()), 64'd2);
        chk("bnd_wr_b_to_aw_gap", 64'(aw_cyc_q[1] - b_cyc_q[0]), 64'd2);
        chk("bnd_wr_error_set", 64'(error), 64'd1);
        repeat (3) tick();
        chk("bnd_wr_error_sticky", 64'(error), 64'd1);

        // Zero length: done pulse, error cleared, no AXI traffic.
        clear_logs();
        go(32'h1234, 0, 1'b0);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_error_cleared", 64'(error), 64'd0);
        tick();
        chk("len0_done_pulse", 64'(done), 64'd0);
        chk("len0_ready", 64'(ready), 64'd1);
        repeat (2) tick();
        chk("len0_no_valids", 64'(valid_seen), 64'd0);

        // Unaligned read split at a 4 KB line, out_ready toggling.
        clear_logs();
        snk_en = 1'b1; snk_tgl = 1'b1;
        go(32'h0FFD, 6, 1'b1);
        wait_done("bnd_rd", 100);
        snk_en = 1'b0; snk_tgl = 1'b0;
        chk("bnd_rd_ar_count", 64'(ar_addr_q.size()), 64'd2);
        chk("bnd_rd_addrs", {ar_addr_q[0], ar_addr_q[1]}, {32'h0FFC, 32'h1000});
        chk("bnd_rd_lens", 64'({ar_len_q[0][7:0], ar_len_q[1][7:0]}), 64'd0);
        chk("bnd_rd_strb", pack_strb(o_strb_q), 64'h7E);
        chk("bnd_rd_last", pack_bits(o_last_q), 64'b10);
        chk("bnd_rd_rlast_to_ar_gap", 64'(ar_cyc_q[1] - rl_cyc_q[0]), 64'd2);

        // Burst cap: 250 beats as 15 x 16 + 10.
        clear_logs();
        src_en = 1'b1;
        go(32'h0, 1000, 1'b0);
        wait_done("cap_wr", 1500);
        src_en = 1'b0;
        chk("cap_wr_aw_count", 64'(aw_addr_q.size()), 64'd16);
        chk("cap_wr_len_first", 64'(aw_len_q[0]), 64'd15);
        chk("cap_wr_len_last", 64'(aw_len_q[15]), 64'd9);
        chk("cap_wr_addr_last", 64'(aw_addr_q[15]), 64'h3C0);
        chk("cap_wr_beats", 64'(w_strb_q.size()), 64'd250);
        chk("cap_wr_strb_last", 64'(w_strb_q[249]), 64'hF);
        chk("cap_wr_wlast_count", 64'(count_ones(w_last_q)), 64'd16);
        chk("cap_wr_error", 64'(error), 64'd0);

        // Reset during a stalled read burst, then a fresh write.
        clear_logs();
        go(32'h2000, 64, 1'b1);
        repeat (4) tick();
        chk("mid_rst_busy_valid", 64'({ready, out_valid}), 64'b01);
        rst = 1'b0;
        tick();
        chk("mid_rst_ready", 64'(ready), 64'd1);
        chk("mid_rst_valids", 64'({awvalid, arvalid, wvalid, out_valid, rready, bready, in_ready, out_last, done}), 64'd0);
        rst = 1'b1;
        tick();
        clear_logs();
        src_en = 1'b1;
        go(32'h40, 8, 1'b0);
        wait_done("post_rst", 100);
        src_en = 1'b0;
        chk("post_rst_aw", {aw_addr_q[0], 32'(aw_len_q[0])}, {32'h40, 32'd1});
        chk("post_rst_aw_count", 64'(aw_addr_q.size()), 64'd1);
        chk("post_rst_strb", pack_strb(w_strb_q), 64'hFF);
        chk("post_rst_wlast", pack_bits(w_last_q), 64'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
